// File: rtl/pelican_mac_sequencer.sv
// pelican_mac_sequencer: feeds the stall-free Pelican MAC core on its fixed schedule and returns the tag
module pelican_mac_sequencer #(
  parameter int MSG_NUM = 3,
  parameter int FIFO_DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] iv_in,
  input  logic [127:0] key_in,
  input  logic         blk_valid,
  input  logic [127:0] blk_data,
  output logic         blk_ready,
  output logic         tag_valid,
  output logic [127:0] tag,
  input  logic         tag_ready,
  output logic         busy,
  output logic         err_underrun,
  output logic         mac_rst,
  output logic         mac_load_iv,
  output logic [127:0] mac_din,
  input  logic         mac_load_k,
  input  logic         mac_load_m,
  input  logic [127:0] mac_dout,
  input  logic         mac_done
);
  localparam int NB = MSG_NUM + 1;
  localparam int FILL_N = FIFO_DEPTH < NB ? FIFO_DEPTH : NB;
  localparam int AW = FIFO_DEPTH > 1 ? $clog2(FIFO_DEPTH) : 1;
  localparam int FW = $clog2(FIFO_DEPTH + 1);
  localparam int CW = $clog2(NB + 1);
  typedef enum logic [2:0] {S_IDLE, S_FILL, S_LOAD, S_RUN, S_OUT} state_t;
  state_t r_state, w_next;
  logic [127:0] r_iv, r_key, r_tag;
  logic [127:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wp, r_rp;
  logic [FW-1:0] r_cnt;
  logic [CW-1:0] r_acc;
  logic r_xor_pend, r_tag_valid, r_err;
  logic w_full, w_empty, w_ready, w_push, w_xor, w_pop;
  logic [127:0] w_head;
  function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
    return p == AW'(FIFO_DEPTH - 1) ? '0 : p + AW'(1);
  endfunction
  assign w_full = r_cnt == FW'(FIFO_DEPTH);
  assign w_empty = r_cnt == '0;
  assign w_ready = (r_state == S_FILL || r_state == S_RUN) && !w_full && r_acc < CW'(NB);
  assign w_push = blk_valid && w_ready;
  assign w_xor = r_state == S_RUN && r_xor_pend;
  assign w_pop = w_xor && !w_empty;
  assign w_head = w_empty ? '0 : r_mem[r_rp];
  assign blk_ready = w_ready;
  assign tag_valid = r_tag_valid;
  assign tag = r_tag;
  assign busy = r_state != S_IDLE;
  assign err_underrun = r_err;
  // next state and core-facing drive; key load beats the message XOR, an empty FIFO drives zero
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  w_next = start ? S_FILL : S_IDLE;
      S_FILL:  w_next = r_cnt >= FW'(FILL_N) ? S_LOAD : S_FILL;
      S_LOAD:  w_next = S_RUN;
      S_RUN:   w_next = mac_done ? S_OUT : S_RUN;
      S_OUT:   w_next = (r_tag_valid && tag_ready) ? S_IDLE : S_OUT;
      default: w_next = S_IDLE;
    endcase
    mac_rst = r_state != S_RUN;
    mac_load_iv = r_state == S_LOAD;
    mac_din = r_state == S_LOAD ? r_iv : r_state != S_RUN ? '0 : mac_load_k ? r_key : w_xor ? w_head : '0;
  end
  // state, FIFO pointers, block counters, sticky underrun and the returned tag
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_iv <= '0;
      r_key <= '0;
      r_wp <= '0;
      r_rp <= '0;
      r_cnt <= '0;
      r_acc <= '0;
      r_xor_pend <= 1'b0;
      r_err <= 1'b0;
      r_tag <= '0;
      r_tag_valid <= 1'b0;
    end else begin
      r_state <= w_next;
      r_xor_pend <= r_state == S_RUN && mac_load_m;
      if (r_state == S_IDLE && start) begin
        r_iv <= iv_in;
        r_key <= key_in;
        r_err <= 1'b0;
        r_acc <= '0;
        r_cnt <= '0;
        r_wp <= '0;
        r_rp <= '0;
      end else begin
        if (w_push) r_wp <= nxt(r_wp);
        if (w_pop) r_rp <= nxt(r_rp);
        r_cnt <= r_cnt + FW'(w_push) - FW'(w_pop);
        r_acc <= r_acc + CW'(w_push);
        if (w_xor && w_empty) r_err <= 1'b1;
      end
      if (r_state == S_RUN && mac_done) begin
        r_tag <= mac_dout;
        r_tag_valid <= 1'b1;
      end else if (r_state == S_OUT && tag_ready) begin
        r_tag_valid <= 1'b0;
      end
    end
  end
  // message block storage
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wp] <= blk_data;
  end
endmodule

// File: tb/tb_pelican_mac_sequencer.sv
// tb_pelican_mac_sequencer: directed runs against a cycle-exact stand-in for the MAC core schedule
module tb_pelican_mac_sequencer;
  logic clk = 1'b0;
  logic rst, start, blk_valid, tag_ready;
  logic [127:0] iv_in, key_in, blk_data;
  logic blk_ready, tag_valid, busy, err_underrun, mac_rst, mac_load_iv;
  logic [127:0] tag, mac_din;
  logic mac_load_k, mac_load_m, mac_done;
  logic [127:0] mac_dout;
  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int c = 0;
  logic [127:0] s = '0;
  logic [127:0] logk [4];
  logic [127:0] logm [4];
  logic [127:0] logz;
  logic loge5, loge6, logr;
  logic [127:0] blk [4];
  int rel [4];
  int nblk = 0;
  int hi = 0;
  logic acc;
  int iv_cnt = 0;
  int t0 = 0;
  int tv = -1;
  logic [127:0] iv_din;
  localparam logic [127:0] K1 = 128'h2b7e1516_28aed2a6_abf71588_09cf4f3c;
  localparam logic [127:0] K2 = 128'h00010203_04050607_08090a0b_0c0d0e0f;
  localparam logic [127:0] IV1 = 128'hf0e1d2c3_b4a59687_78695a4b_3c2d1e0f;

  pelican_mac_sequencer #(.MSG_NUM(3), .FIFO_DEPTH(2)) dut (
    .clk(clk), .rst(rst), .start(start), .iv_in(iv_in), .key_in(key_in),
    .blk_valid(blk_valid), .blk_data(blk_data), .blk_ready(blk_ready),
    .tag_valid(tag_valid), .tag(tag), .tag_ready(tag_ready), .busy(busy),
    .err_underrun(err_underrun), .mac_rst(mac_rst), .mac_load_iv(mac_load_iv),
    .mac_din(mac_din), .mac_load_k(mac_load_k), .mac_load_m(mac_load_m),
    .mac_dout(mac_dout), .mac_done(mac_done)
  );

  initial forever #5 clk = ~clk;

  assign mac_load_k = c == 2 || c == 3 || c == 126 || c == 127;
  assign mac_load_m = c == 43 || c == 70 || c == 97 || c == 124;
  assign mac_done = c == 168;
  assign mac_dout = s;

  // free-running cycle count
  always @(posedge clk) cyc <= cyc + 1;

  // core stand-in: cycle counter from T0, folds every sampled din into a rotating state, logs din at fixed cycles
  always @(posedge clk) begin
    if (rst || mac_rst) begin
      c <= (!rst && mac_load_iv) ? 1 : 0;
      if (!rst && mac_load_iv) begin
        s <= mac_din;
        for (int i = 0; i < 4; i++) begin
          logk[i] <= 128'hbad;
          logm[i] <= 128'hbad;
        end
        logz <= 128'hbad;
      end
    end else begin
      c <= c + 1;
      if (mac_load_k || c == 44 || c == 71 || c == 98 || c == 125) s <= {s[126:0], s[127]} ^ mac_din;
      case (c)
        1: logz <= mac_din;
        2, 3: logk[c-2] <= mac_din;
        126, 127: logk[c-124] <= mac_din;
        44, 71, 98, 125: logm[(c-44)/27] <= mac_din;
        default: ;
      endcase
      if (c == 125) loge5 <= err_underrun;
      if (c == 126) loge6 <= err_underrun;
      if (c == 130) logr <= blk_ready;
    end
  end

  // host block source: block i shows up immediately (rel 0) or once the core reaches cycle rel[i]
  initial begin
    blk_valid = 1'b0;
    blk_data = '0;
    acc = 1'b0;
    forever begin
      @(negedge clk);
      if (acc) hi++;
      blk_valid = hi < nblk && (rel[hi] == 0 || (!mac_rst && c >= rel[hi]));
      blk_data = hi < nblk ? blk[hi] : '0;
      #1 acc = blk_valid && blk_ready;
    end
  end

  // observes the load_iv strobe and the first tag_valid cycle of each run
  always @(negedge clk) begin
    if (start && !busy) begin
      iv_cnt = 0;
      tv = -1;
    end
    if (mac_load_iv) begin
      iv_cnt++;
      t0 = cyc;
      iv_din = mac_din;
    end
    if (tag_valid && tv < 0) tv = cyc;
  end

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic logic [127:0] model(input logic [127:0] iv, k, b0, b1, b2, b3);
    logic [127:0] r;
    logic [127:0] v [8];
    v = '{k, k, b0, b1, b2, b3, k, k};
    r = iv;
    foreach (v[i]) r = {r[126:0], r[127]} ^ v[i];
    return r;
  endfunction

  task automatic kick(input logic [127:0] iv, k, input int n, r2, r3, hold);
    @(posedge clk);
    #2;
    nblk = n;
    rel = '{0, 0, r2, r3};
    hi = 0;
    acc = 1'b0;
    tag_ready = hold == 0;
    iv_in = iv;
    key_in = k;
    start = 1'b1;
    @(posedge clk);
    #2 start = 1'b0;
  endtask

  task automatic run(input string nm, input logic [127:0] iv, k, input int n, r2, r3, hold);
    logic [127:0] bb [4];
    logic [127:0] e;
    for (int j = 0; j < 4; j++) bb[j] = j < n ? blk[j] : '0;
    e = model(iv, k, bb[0], bb[1], bb[2], bb[3]);
    kick(iv, k, n, r2, r3, hold);
    @(negedge clk);
    check({nm, ".busy_start"}, 128'(busy), 128'(1));
    check({nm, ".err_clr"}, 128'(err_underrun), 128'(0));
    for (int i = 0; i < 400 && !tag_valid; i++) @(negedge clk);
    #1;
    check({nm, ".tag_valid"}, 128'(tag_valid), 128'(1));
    check({nm, ".tag"}, tag, e);
    check({nm, ".tv_lat"}, 128'(tv - t0), 128'(169));
    check({nm, ".iv_once"}, 128'(iv_cnt), 128'(1));
    check({nm, ".iv_din"}, iv_din, iv);
    check({nm, ".idle_din"}, logz, 128'(0));
    for (int j = 0; j < 4; j++) check($sformatf("%s.key%0d", nm, j), logk[j], k);
    for (int j = 0; j < 4; j++) check($sformatf("%s.blk%0d", nm, j), logm[j], bb[j]);
    check({nm, ".err125"}, 128'(loge5), 128'(0));
    check({nm, ".err126"}, 128'(loge6), 128'(n < 4));
    check({nm, ".ready130"}, 128'(logr), 128'(n < 4));
    check({nm, ".err_sticky"}, 128'(err_underrun), 128'(n < 4));
    for (int i = 0; i < hold; i++) begin
      start = i == 5;
      @(negedge clk);
      check({nm, ".hold_tag"}, tag, e);
      check({nm, ".hold_tv"}, 128'(tag_valid), 128'(1));
      check({nm, ".hold_busy"}, 128'(busy), 128'(1));
    end
    start = 1'b0;
    tag_ready = 1'b1;
    @(negedge clk);
    check({nm, ".idle_busy"}, 128'(busy), 128'(0));
    check({nm, ".idle_tv"}, 128'(tag_valid), 128'(0));
    @(negedge clk);
    check({nm, ".stay_idle"}, 128'(busy), 128'(0));
  endtask

  task automatic mid_rst();
    kick(IV1, K1, 4, 0, 0, 0);
    for (int i = 0; i < 300 && !(c == 60 && !mac_rst); i++) @(negedge clk);
    check("rst.reach60", 128'(c), 128'(60));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst.busy", 128'(busy), 128'(0));
    check("rst.mac_rst", 128'(mac_rst), 128'(1));
    check("rst.tag_valid", 128'(tag_valid), 128'(0));
    check("rst.blk_ready", 128'(blk_ready), 128'(0));
    check("rst.din", mac_din, 128'(0));
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got no end expected end");
    $fatal(1);
  end

  initial begin
    blk = '{128'h6bc1bee2_2e409f96_e93d7e11_7393172a, 128'hae2d8a57_1e03ac9c_9eb76fac_45af8e51,
            128'h30c81c46_a35ce411_e5fbc119_1a0a52ef, 128'hf69f2445_df4f9b17_ad2b417b_e66c3710};
    rst = 1'b1;
    start = 1'b0;
    tag_ready = 1'b1;
    iv_in = '0;
    key_in = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset.busy", 128'(busy), 128'(0));
    check("reset.mac_rst", 128'(mac_rst), 128'(1));
    check("reset.load_iv", 128'(mac_load_iv), 128'(0));
    check("reset.din", mac_din, 128'(0));
    check("reset.blk_ready", 128'(blk_ready), 128'(0));
    check("reset.tag_valid", 128'(tag_valid), 128'(0));
    check("reset.tag", tag, 128'(0));
    check("reset.err", 128'(err_underrun), 128'(0));
    rst = 1'b0;
    run("all_early", '0, K1, 4, 0, 0, 0);
    run("late_blocks", '0, K1, 4, 90, 120, 0);
    run("push_pop", '0, K1, 4, 71, 80, 0);
    run("underrun", '0, K1, 3, 0, 0, 0);
    run("tag_hold", IV1, K2, 4, 0, 0, 20);
    mid_rst();
    run("after_rst", '0, K1, 4, 0, 0, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/pelican_mac_sequencer.md
Name: pelican_mac_sequencer

Overview:
- Host-side controller for the Pelican MAC core; the core has no stall input, so this block must run ahead of it.
- Latches IV and key on a start command and buffers incoming 128-bit message blocks in a small FIFO.
- Drives the core's rst, load_iv and din at the exact cycles the core samples them, using the core's load_k/load_m strobes.
- Captures the core's dout on done and returns the tag through a valid/ready handshake.

Parameters:
MSG_NUM, 3, message length is MSG_NUM+1 blocks; must equal the core's compile-time MSG_NUM
FIFO_DEPTH, 4, message-block FIFO entries (>=1, power of two)

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
start  in  1  begin one MAC computation (honoured only in IDLE)
iv_in  in  128  IV, sampled with start
key_in  in  128  key, sampled with start
blk_valid  in  1  message block valid
blk_data  in  128  message block
blk_ready  out  1  block accepted when blk_valid&blk_ready
tag_valid  out  1  tag available
tag  out  128  MAC tag
tag_ready  in  1  tag consumed when tag_valid&tag_ready
busy  out  1  state!=IDLE
err_underrun  out  1  sticky: FIFO was empty at a message-XOR cycle
mac_rst  out  1  to core rst
mac_load_iv  out  1  to core load_iv
mac_din  out  128  to core din
mac_load_k  in  1  core key-load strobe
mac_load_m  in  1  core strobe: block needed next cycle
mac_dout  in  128  core state
mac_done  in  1  core finished

Behaviour:
Reset values:
- FSM=IDLE; FIFO empty; accepted-block count=0; tag_valid=0; tag=0; err_underrun=0.
- mac_rst=1, mac_load_iv=0, mac_din=0, blk_ready=0.

FSM states:
- IDLE: mac_rst=1. On start, latch iv_in/key_in, clear err_underrun and counters, go to FILL.
- FILL: mac_rst=1. Go to LOAD when FIFO count >= min(FIFO_DEPTH, MSG_NUM+1).
- LOAD: exactly one cycle with mac_rst=1, mac_load_iv=1, mac_din=IV. Next state RUN. Call this cycle T0.
- RUN: mac_rst=0. On mac_done, register tag<=mac_dout and tag_valid<=1 (visible next cycle), go to OUT.
- OUT: hold tag and mac_rst=1. On tag_valid&tag_ready, clear tag_valid and go to IDLE.

mac_din in RUN (combinational select, priority order):
- key when mac_load_k=1;
- FIFO head when xor_pend=1, where xor_pend is mac_load_m registered one cycle;
- 0 otherwise.
- On the xor_pend cycle the FIFO pops. If the FIFO is empty: drive 0, set err_underrun, continue; the core is never stalled.

blk_ready:
- = (state is FILL or RUN) & FIFO not full & accepted count < MSG_NUM+1.
- Accepted count saturates at MSG_NUM+1 per computation.
- Push and pop in the same cycle are legal: count is unchanged, and a pop of the written entry sees the old head.

Core timing (MSG_NUM=3):
- Core idle T0+1; key load T0+2..T0+3; encryption T0+4..T0+43.
- mac_load_m at T0+43, T0+70, T0+97, T0+124; XOR cycles at T0+44, T0+71, T0+98, T0+125.
- Key reloaded at T0+126..T0+127; mac_done at T0+168; tag_valid at T0+169.
- Generally, the k-th XOR (k=0..MSG_NUM) is at T0+44+27k.

Other rules:
- start outside IDLE is ignored.
- rst at any time returns to IDLE and flushes the FIFO; a pending tag is lost.
- mac_load_m while not in RUN is ignored.

Test Plan:
- IV=0, key=K1, four blocks present before FILL ends -> mac_load_iv high only at T0 with din=IV; din=K1 at T0+2, T0+3, T0+126, T0+127; blocks B0..B3 on din at T0+44/71/98/125; tag equals reference-model Pelican(K1,IV,B0..B3); tag_valid at T0+169; err_underrun=0.
- FIFO_DEPTH=2; host supplies B2 at T0+90 and B3 at T0+120 -> same tag as above; blk_ready low once 4 blocks are accepted.
- B3 withheld -> din=0 at T0+125; err_underrun=1 from T0+126 until the next start; tag equals model with B3=0.
- tag_ready held low 20 cycles after tag_valid -> tag and tag_valid stable, busy=1, start ignored; tag_ready=1 -> IDLE next cycle.
- rst asserted at T0+60 -> next cycle: IDLE, mac_rst=1, FIFO empty, tag_valid=0; a fresh run then produces the correct tag.
- blk_valid with push and pop in the same cycle while FIFO holds 1 entry -> block order preserved, no loss or duplication.
